dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    ARB_RR     = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just after ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;

  // Walk from farthest to nearest so the nearest eligible index is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = N; i >= 1; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - independent write/read round-robin arbiters onto a 1R1W data memory
// Define DMEM_ARB_LOCK_EN to enable grant locking through req_lock.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int memDepth = 12
) (
  input  logic                                   clk,
  input  logic                                   RESET,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0]                     req_we,
  input  logic [NUM_REQ-1:0][memDepth-1:0]       req_addr,
  input  logic [NUM_REQ-1:0][DMEM_DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0]                     req_lock,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic [DMEM_DATA_W-1:0]                 rsp_data,
  output logic [memDepth-1:0]                    mem_InAddress,
  output logic [DMEM_DATA_W-1:0]                 mem_DataIn,
  output logic                                   mem_WE,
  output logic [memDepth-1:0]                    mem_OutAddress,
  input  logic [DMEM_DATA_W-1:0]                 mem_DataOut
);

  localparam int PW = $clog2(NUM_REQ);
`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic [NUM_REQ-1:0]            lock_vec;
  logic [1:0][NUM_REQ-1:0]       elig;
  logic [1:0][NUM_REQ-1:0]       grant;
  logic [1:0][PW-1:0]            gidx;

  assign lock_vec = LOCK_EN ? req_lock : '0;
  assign elig[0]  = req_valid & req_we;
  assign elig[1]  = req_valid & ~req_we;

  // Arbiter 0 serves writes, arbiter 1 serves reads; ptr_q always holds the last grantee.
  for (genvar k = 0; k < 2; k++) begin : g_arb
    arb_state_t          state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d, idx;
    logic [NUM_REQ-1:0]  rr_grant, gnt;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
      .eligible (elig[k]),
      .ptr      (ptr_q),
      .grant    (rr_grant)
    );

    always_comb begin
      gnt = rr_grant;
      if (state_q == ARB_LOCKED && elig[k][ptr_q] && lock_vec[ptr_q]) begin
        gnt        = '0;
        gnt[ptr_q] = 1'b1;
      end
      if (!RESET) gnt = '0;
      idx = ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) idx = PW'(i);
      end
      ptr_d   = idx;
      state_d = (|gnt && lock_vec[idx]) ? ARB_LOCKED : ARB_RR;
    end

    always_ff @(posedge clk) begin
      if (!RESET) begin
        state_q <= ARB_RR;
        ptr_q   <= PW'(NUM_REQ - 1);
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
      end
    end

    assign grant[k] = gnt;
    assign gidx[k]  = idx;
  end

  assign req_ready      = grant[0] | grant[1];
  assign mem_WE         = |grant[0];
  assign mem_InAddress  = req_addr[gidx[0]];
  assign mem_DataIn     = req_wdata[gidx[0]];
  assign mem_OutAddress = req_addr[gidx[1]];

  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                   byp_q, byp_d;
  logic [DMEM_DATA_W-1:0] byp_data_q, byp_data_d;

  // Same-address write in the read's grant cycle: memory returns stale data, so forward.
  always_comb begin
    rsp_valid_d = grant[1];
    byp_d       = mem_WE && (|grant[1]) && (mem_InAddress == mem_OutAddress);
    byp_data_d  = mem_DataIn;
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      rsp_valid_q <= '0;
      byp_q       <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      byp_q       <= byp_d;
      byp_data_q  <= byp_data_d;
    end
  end

  assign rsp_valid = RESET ? rsp_valid_q : '0;
  assign rsp_data  = byp_q ? byp_data_q : mem_DataOut;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic             clk = 1'b0;
  logic             RESET;
  logic [3:0]       req_valid, req_we, req_lock, req_ready, rsp_valid;
  logic [3:0][11:0] req_addr;
  logic [3:0][31:0] req_wdata;
  logic [31:0]      rsp_data, mem_DataIn, mem_DataOut;
  logic [11:0]      mem_InAddress, mem_OutAddress;
  logic             mem_WE;

  logic [3:0][11:0] na;
  logic [3:0][31:0] nd;
  logic [31:0]      mem [0:4095];
  logic [3:0]       seq [4];
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_REQ(4), .memDepth(12)) dut (
    .clk            (clk),
    .RESET          (RESET),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_lock       (req_lock),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .mem_InAddress  (mem_InAddress),
    .mem_DataIn     (mem_DataIn),
    .mem_WE         (mem_WE),
    .mem_OutAddress (mem_OutAddress),
    .mem_DataOut    (mem_DataOut)
  );

  always @(posedge clk) begin
    if (!RESET) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
    end else begin
      if (mem_WE) mem[mem_InAddress] <= mem_DataIn;
      mem_DataOut <= mem[mem_OutAddress];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [3:0] v, input logic [3:0] w, input logic [3:0] lk, input logic rst);
    @(negedge clk);
    RESET     = rst;
    req_valid = v;
    req_we    = w;
    req_lock  = lk;
    req_addr  = na;
    req_wdata = nd;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0; req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    nd = '0;
    na = {12'h103, 12'h102, 12'h101, 12'h100};
    repeat (2) @(negedge clk);

    apply(4'hF, 4'h0, 4'h0, 1'b0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we", 32'(mem_WE), 32'h0);
    chk("rst_rsp", 32'(rsp_valid), 32'h0);
    apply(4'h0, 4'h0, 4'h0, 1'b0);
    apply(4'h0, 4'h0, 4'h0, 1'b1);

    // all four read continuously
    for (int c = 0; c < 8; c++) begin
      apply(4'hF, 4'h0, 4'h0, 1'b1);
      chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      chk("rr_we", 32'(mem_WE), 32'h0);
      chk("rr_rsp_valid", 32'(rsp_valid), (c == 0) ? 32'h0 : 32'(1 << ((c - 1) % 4)));
      if (c > 0) chk("rr_rsp_data", rsp_data, 32'hC0DE0100 + 32'((c - 1) % 4));
    end
    apply(4'h0, 4'h0, 4'h0, 1'b1);
    chk("rr_last_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("rr_last_rsp_data", rsp_data, 32'hC0DE0103);
    chk("idle_ready", 32'(req_ready), 32'h0);

    // same-address write/read -> bypass
    na = '0; nd = '0;
    na[1] = 12'h010; nd[1] = 32'hDEADBEEF; na[2] = 12'h010;
    apply(4'b0110, 4'b0010, 4'h0, 1'b1);
    chk("raw_ready", 32'(req_ready), 32'h6);
    chk("raw_we", 32'(mem_WE), 32'h1);
    chk("raw_waddr", 32'(mem_InAddress), 32'h010);
    chk("raw_wdata", mem_DataIn, 32'hDEADBEEF);
    chk("raw_raddr", 32'(mem_OutAddress), 32'h010);
    apply(4'h0, 4'h0, 4'h0, 1'b1);
    chk("raw_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("raw_rsp_data", rsp_data, 32'hDEADBEEF);

    // concurrent write and read to different addresses
    na = '0; nd = '0;
    na[0] = 12'h020; nd[0] = 32'h12345678; na[3] = 12'h030;
    apply(4'b1001, 4'b0001, 4'h0, 1'b1);
    chk("wr_rd_ready", 32'(req_ready), 32'h9);
    chk("wr_rd_we", 32'(mem_WE), 32'h1);
    chk("wr_rd_waddr", 32'(mem_InAddress), 32'h020);
    chk("wr_rd_raddr", 32'(mem_OutAddress), 32'h030);
    apply(4'h0, 4'h0, 4'h0, 1'b1);
    chk("wr_rd_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("wr_rd_rsp_data", rsp_data, 32'hC0DE0030);

    // lock: move read pointer to 1, then req2 locks against req0
    na = '0; nd = '0;
    na[1] = 12'h040;
    apply(4'b0010, 4'h0, 4'h0, 1'b1);
    chk("lk_pre_ready", 32'(req_ready), 32'h2);
`ifdef DMEM_ARB_LOCK_EN
    seq[0] = 4'b0100; seq[1] = 4'b0100; seq[2] = 4'b0100; seq[3] = 4'b0001;
`else
    seq[0] = 4'b0100; seq[1] = 4'b0001; seq[2] = 4'b0100; seq[3] = 4'b0001;
`endif
    na[2] = 12'h050; na[0] = 12'h060;
    for (int c = 0; c < 4; c++) begin
      apply((c < 3) ? 4'b0101 : 4'b0001, 4'h0, (c < 3) ? 4'b0100 : 4'h0, 1'b1);
      chk("lk_ready", 32'(req_ready), 32'(seq[c]));
      chk("lk_rsp_valid", 32'(rsp_valid), (c == 0) ? 32'h2 : 32'(seq[c-1]));
    end
    apply(4'h0, 4'h0, 4'h0, 1'b1);
    chk("lk_last_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("lk_last_rsp_data", rsp_data, 32'hC0DE0060);

    // reset right after a read grant
    na = '0;
    na[1] = 12'h080;
    apply(4'b0010, 4'h0, 4'h0, 1'b1);
    chk("rg_ready", 32'(req_ready), 32'h2);
    apply(4'h0, 4'h0, 4'h0, 1'b0);
    chk("rg_rsp_in_reset", 32'(rsp_valid), 32'h0);
    apply(4'h0, 4'h0, 4'h0, 1'b1);
    chk("rg_rsp_after_reset", 32'(rsp_valid), 32'h0);
    na = {12'h093, 12'h092, 12'h091, 12'h090};
    apply(4'hF, 4'h0, 4'h0, 1'b1);
    chk("rg_first_grant", 32'(req_ready), 32'h1);
    apply(4'h0, 4'h0, 4'h0, 1'b1);
    chk("rg_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rg_rsp_data", rsp_data, 32'hC0DE0090);

    // idle, then requester 3 alone
    for (int c = 0; c < 5; c++) begin
      apply(4'h0, 4'h0, 4'h0, 1'b1);
      chk("idle_we", 32'(mem_WE), 32'h0);
      chk("idle_ready", 32'(req_ready), 32'h0);
    end
    na = '0; nd = '0;
    na[3] = 12'h070; nd[3] = 32'hCAFEF00D;
    apply(4'b1000, 4'b1000, 4'h0, 1'b1);
    chk("r3_wr_ready", 32'(req_ready), 32'h8);
    chk("r3_wr_we", 32'(mem_WE), 32'h1);
    apply(4'b1000, 4'h0, 4'h0, 1'b1);
    chk("r3_rd_ready", 32'(req_ready), 32'h8);
    chk("r3_rd_we", 32'(mem_WE), 32'h0);
    apply(4'h0, 4'h0, 4'h0, 1'b1);
    chk("r3_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("r3_rsp_data", rsp_data, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
